instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_watchdog.sv | 28 ++
 rtl/instruction_fetch.sv | 154 +++++++++++++++
 tb/tb_instruction_fetch.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: word/address widths, default reset PC,
// fetch state encoding and a word-alignment helper.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_t;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive cycles of an unanswered fetch request; flags expiry on the
// cycle the count would reach TIMEOUT.
module fetch_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (waiting) begin
      count <= count + CW'(1);
    end else begin
      count <= '0;
    end
  end

  assign expired = waiting && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: sequential fetch, one-entry stall buffer, branch flush.
// Optional fetch watchdog and FAULT state enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter int                FETCH_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [WORD_W-1:0] instruction,
  output logic [ADDR_W-1:0] pc_out,
  output logic              enable,
  output logic              fault
);

  // Memory handshake: mem_read/mem_addr are held stable until the cycle in which
  // mem_ready=1; that cycle completes the transfer and mem_rdata is sampled then.
  // Decoder side: enable is a one-cycle valid with no back-pressure on the pulse
  // itself; stall prevents a new pulse from being generated.

  if (FETCH_TIMEOUT < 1) begin : g_bad_timeout
    $error("FETCH_TIMEOUT must be at least 1");
  end

  fetch_state_t      state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic [WORD_W-1:0] instr_d, hold_word, hold_word_d;
  logic [ADDR_W-1:0] pc_out_d, hold_pc, hold_pc_d;
  logic              enable_d;

`ifdef FETCH_TIMEOUT_EN
  logic wd_waiting, wd_expired;

  assign wd_waiting = (state == ST_FETCH) && !mem_ready && !branch_taken;

  fetch_watchdog #(.TIMEOUT(FETCH_TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .waiting (wd_waiting),
    .expired (wd_expired)
  );

  assign fault = (state == ST_FAULT);
`else
  assign fault = 1'b0;
`endif

  assign mem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= align_word(RESET_PC);
      instruction <= '0;
      pc_out      <= '0;
      enable      <= 1'b0;
      hold_word   <= '0;
      hold_pc     <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      instruction <= instr_d;
      pc_out      <= pc_out_d;
      enable      <= enable_d;
      hold_word   <= hold_word_d;
      hold_pc     <= hold_pc_d;
    end
  end

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    instr_d     = instruction;
    pc_out_d    = pc_out;
    enable_d    = 1'b0;
    hold_word_d = hold_word;
    hold_pc_d   = hold_pc;
    mem_read    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (branch_taken) begin
          pc_d    = align_word(branch_target);
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        mem_read = 1'b1;
        // A redirect discards whatever the memory returns this cycle.
        if (branch_taken) begin
          pc_d    = align_word(branch_target);
          state_d = ST_FLUSH;
        end else if (mem_ready && !stall) begin
          instr_d  = mem_rdata;
          pc_out_d = pc;
          enable_d = 1'b1;
          pc_d     = pc + ADDR_W'(4);
        end else if (mem_ready) begin
          hold_word_d = mem_rdata;
          hold_pc_d   = pc;
          pc_d        = pc + ADDR_W'(4);
          state_d     = ST_HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wd_expired) begin
          state_d = ST_FAULT;
        end
`endif
      end

      ST_HOLD: begin
        if (branch_taken) begin
          pc_d    = align_word(branch_target);
          state_d = ST_FLUSH;
        end else if (!stall) begin
          instr_d  = hold_word;
          pc_out_d = hold_pc;
          enable_d = 1'b1;
          state_d  = ST_FETCH;
        end
      end

      ST_FLUSH: begin
        if (branch_taken) begin
          pc_d = align_word(branch_target);
        end else begin
          state_d = ST_FETCH;
        end
      end

`ifdef FETCH_TIMEOUT_EN
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized traffic, all checked against a behavioural fetch model.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC      = 32'h0000_0000;
  localparam int          FETCH_TIMEOUT = 16;
`ifdef FETCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        enable;
  logic        fault;

  instruction_fetch #(
    .RESET_PC      (RESET_PC),
    .FETCH_TIMEOUT (FETCH_TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_addr      (mem_addr),
    .mem_read      (mem_read),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instruction   (instruction),
    .pc_out        (pc_out),
    .enable        (enable),
    .fault         (fault)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Instruction memory: hashed contents with directed overrides.
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model. exp_q holds fetched-but-undelivered {pc, word} entries.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc, m_instr, m_pcout;
  bit          m_idle, m_flush, m_en, m_fault;
  int          m_wait;

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_idle  = 1'b1;
    m_flush = 1'b0;
    m_en    = 1'b0;
    m_fault = 1'b0;
    m_instr = '0;
    m_pcout = '0;
    m_wait  = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit r, input bit s, input bit b,
                            input logic [31:0] t, input logic [31:0] d);
    logic [63:0] e;
    m_en = 1'b0;
    if (m_fault) begin
      // only reset leaves a fault
    end else if (m_idle) begin
      m_idle = 1'b0;
      if (b) begin
        m_pc    = {t[31:2], 2'b00};
        m_flush = 1'b1;
      end
    end else if (m_flush) begin
      if (b) m_pc = {t[31:2], 2'b00};
      else   m_flush = 1'b0;
    end else if (b) begin
      m_pc    = {t[31:2], 2'b00};
      m_flush = 1'b1;
      m_wait  = 0;
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      if (!s) begin
        e       = exp_q.pop_front();
        m_pcout = e[63:32];
        m_instr = e[31:0];
        m_en    = 1'b1;
      end
    end else if (r) begin
      m_wait = 0;
      if (s) begin
        exp_q.push_back({m_pc, d});
      end else begin
        m_instr = d;
        m_pcout = m_pc;
        m_en    = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else begin
      m_wait++;
      if (TO_EN && m_wait == FETCH_TIMEOUT) m_fault = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    logic exp_read;
    exp_read = !(m_idle || m_flush || (exp_q.size() != 0) || m_fault);
    chk("mem_read", 32'(mem_read), 32'(exp_read));
    if (exp_read) chk("mem_addr", mem_addr, m_pc);
    chk("enable", 32'(enable), 32'(m_en));
    if (m_en) begin
      chk("instruction", instruction, m_instr);
      chk("pc_out", pc_out, m_pcout);
    end
    chk("fault", 32'(fault), 32'(m_fault));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, RESET_PC);
    chk({tag, "_enable"}, 32'(enable), 32'd0);
    chk({tag, "_instruction"}, instruction, 32'd0);
    chk({tag, "_pc_out"}, pc_out, 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  // Driver: inputs change on the falling edge, model advances on the rising
  // edge, outputs are checked on the next falling edge.
  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t);
    mem_ready     = r;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    mem_rdata     = r ? mem_word(mem_addr) : $urandom();
    @(posedge clk);
    model_step(r, s, b, t, mem_rdata);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    mem_ready     = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    mem_rdata     = '0;
    mem_ovr[32'h0] = 32'hE3A0_1005;
    mem_ovr[32'h4] = 32'hE081_2003;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    check_reset_values("reset");
    reset = 1'b0;

    // Sequential fetch from RESET_PC with 1-cycle memory.
    step(1'b1, 1'b0, 1'b0, '0);
    chk("seq_first_addr", mem_addr, 32'h0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("seq_instr", instruction, 32'hE3A0_1005);
    chk("seq_pc_out", pc_out, 32'h0);
    chk("seq_addr4", mem_addr, 32'h4);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("seq_addr8", mem_addr, 32'h8);
    step(1'b1, 1'b0, 1'b0, '0);

    // Stall while the word at 0x4 returns.
    step(1'b0, 1'b0, 1'b1, 32'h4);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("stall_addr", mem_addr, 32'h4);
    step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 2; i++) begin
      chk("stall_en", 32'(enable), 32'd0);
      chk("stall_read", 32'(mem_read), 32'd0);
      step(1'b0, 1'b1, 1'b0, '0);
    end
    chk("stall_en_last", 32'(enable), 32'd0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("stall_release_instr", instruction, 32'hE081_2003);
    chk("stall_release_pc", pc_out, 32'h4);
    chk("stall_next_addr", mem_addr, 32'h8);

    // Branch during a pending fetch whose word must be dropped.
    mem_ovr[m_pc] = 32'hDEAD_BEEF;
    step(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    chk("branch_en", 32'(enable), 32'd0);
    chk("branch_flush_read", 32'(mem_read), 32'd0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("branch_target_addr", mem_addr, 32'h100);
    chk("branch_target_read", 32'(mem_read), 32'd1);

    // Address wrap at the top of memory.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
    chk("wrap_next_addr", mem_addr, 32'h0);

    // Reset in the middle of an outstanding request.
    step(1'b0, 1'b0, 1'b1, 32'h20);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("midreset_pre_addr", mem_addr, 32'h20);
    #2 reset = 1'b1;
    #1 check_reset_values("midreset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0);
    chk("midreset_first_addr", mem_addr, RESET_PC);

    // Memory never answers.
    for (int i = 0; i < FETCH_TIMEOUT + 4; i++) step(1'b0, 1'b0, 1'b0, '0);
    chk("timeout_fault", 32'(fault), TO_EN ? 32'd1 : 32'd0);
    chk("timeout_read", 32'(mem_read), TO_EN ? 32'd0 : 32'd1);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                        : $urandom();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0, tgt);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
